// File: rtl/alu_scheduler.sv
// Two-requester front end for a shared combinational ALU: round-robin accept,
// one operation in flight, shift-and-add multiply through the ALU adder.
module alu_scheduler #(
  parameter int inst_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic [2:0]           req0_ctrl,
  input  logic [inst_SIZE-1:0] req0_a,
  input  logic [inst_SIZE-1:0] req0_b,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [2:0]           req1_ctrl,
  input  logic [inst_SIZE-1:0] req1_a,
  input  logic [inst_SIZE-1:0] req1_b,
  output logic                 req1_ready,
  output logic [2:0]           alu_ctrl,
  output logic [inst_SIZE-1:0] alu_a,
  output logic [inst_SIZE-1:0] alu_b,
  input  logic [inst_SIZE-1:0] alu_result,
  input  logic                 alu_zero,
  output logic                 rsp_valid,
  output logic                 rsp_id,
  output logic [inst_SIZE-1:0] rsp_data,
  output logic                 rsp_zero,
  input  logic                 rsp_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] MUL  = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]           r_state;
  logic [2:0]           r_ctrl;
  logic [inst_SIZE-1:0] r_a;
  logic [inst_SIZE-1:0] r_b;
  logic                 r_id;
  logic                 r_last;
  logic [3:0]           r_k;
  logic [inst_SIZE-1:0] r_acc;
  logic [inst_SIZE-1:0] r_rsp_data;
  logic                 r_rsp_zero;

  logic                 w_idle;
  logic                 w_gnt0;
  logic                 w_gnt1;
  logic                 w_accept;
  logic [2:0]           w_sel_ctrl;
  logic                 w_undef;
  logic [inst_SIZE-1:0] w_mul_b;

  // On a tie the requester that was not served last wins.
  assign w_idle   = (r_state == IDLE) && !rst;
  assign w_gnt0   = req0_valid && (!req1_valid || r_last);
  assign w_gnt1   = req1_valid && (!req0_valid || !r_last);
  assign req0_ready = w_idle && w_gnt0;
  assign req1_ready = w_idle && w_gnt1;
  assign w_accept   = req0_ready || req1_ready;
  assign w_sel_ctrl = req1_ready ? req1_ctrl : req0_ctrl;

  assign w_undef = (r_ctrl == 3'b101) || (r_ctrl == 3'b110);
  assign w_mul_b = r_b[r_k] ? (r_a << r_k) : '0;

  always_comb begin
    alu_ctrl = 3'b000;
    alu_a    = '0;
    alu_b    = '0;
    case (r_state)
      EXEC: begin
        if (!w_undef) begin
          alu_ctrl = r_ctrl;
          alu_a    = r_a;
          alu_b    = r_b;
        end
      end
      MUL: begin
        alu_a = r_acc;
        alu_b = w_mul_b;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ctrl     <= 3'b000;
      r_a        <= '0;
      r_b        <= '0;
      r_id       <= 1'b0;
      r_last     <= 1'b1;
      r_k        <= 4'd0;
      r_acc      <= '0;
      r_rsp_data <= '0;
      r_rsp_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_ctrl  <= w_sel_ctrl;
            r_a     <= req1_ready ? req1_a : req0_a;
            r_b     <= req1_ready ? req1_b : req0_b;
            r_id    <= req1_ready;
            r_acc   <= '0;
            r_k     <= 4'd0;
            r_state <= (w_sel_ctrl == 3'b111) ? MUL : EXEC;
          end
        end
        EXEC: begin
          r_rsp_data <= w_undef ? '0 : alu_result;
          r_rsp_zero <= w_undef ? 1'b1 : alu_zero;
          r_state    <= RESP;
        end
        MUL: begin
          r_acc <= alu_result;
          r_k   <= r_k + 4'd1;
          if (r_k == 4'd15) begin
            r_rsp_data <= alu_result;
            r_rsp_zero <= (alu_result == '0);
            r_state    <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_last  <= r_id;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = (r_state == RESP);
  assign rsp_id    = r_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_zero  = r_rsp_zero;

endmodule
